dbus_arbiter: RTL and testbench

Round-robin arbiter for the shared data-bus memory port. Three requesters share one single-port synchronous block RAM: the CPU (DbLoad/DbStore path, index 0), the CCD capture engine (index 1) and the NN accelerator (index 2). A granted requester holds the bus for a burst of beats; the other requesters wait. The block also produces a CPU stall signal while the CPU is waiting for its grant.

---
 rtl/dbus_arbiter_if.sv | 41 ++++
 rtl/dbus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dbus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_if.sv
// rtl/dbus_arbiter_if.sv - requester/memory bundle between the data-bus arbiter and its clients
//
// Groups the three-requester handshake and the single-port RAM interface.
//   slave  : arbiter side (consumes requests and mem_rdata, drives grants and the RAM port)
//   master : client side (requesters plus the RAM model)
// Requester i occupies iAddr/iWData bits [i*W +: W]; 0=CPU, 1=CCD, 2=ACC.
interface dbus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [2:0]          iReq;
    logic [2:0]          iWe;
    logic [2:0]          iLast;
    logic [3*ADDR_W-1:0] iAddr;
    logic [3*DATA_W-1:0] iWData;

    logic [2:0]          oGnt;
    logic [2:0]          oAck;
    logic [2:0]          oRValid;
    logic [DATA_W-1:0]   oRData;
    logic [1:0]          oOwner;
    logic                oCpuStall;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  iReq, iWe, iLast, iAddr, iWData, mem_rdata,
        output oGnt, oAck, oRValid, oRData, oOwner, oCpuStall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output iReq, iWe, iLast, iAddr, iWData, mem_rdata,
        input  oGnt, oAck, oRValid, oRData, oOwner, oCpuStall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - round-robin burst arbiter for the shared data-bus RAM port
//
// Three requesters (CPU=0, CCD=1, ACC=2) share one single-port synchronous RAM.
// A granted owner keeps the bus for a burst until it marks iLast, drops iReq,
// or reaches MAX_BEATS accepted beats, after which the next requester in
// round-robin order takes over with no idle cycle in between.
//
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : dbus_arbiter_if.slave
//           inputs  iReq/iWe/iLast/iAddr/iWData (per requester), mem_rdata
//           outputs oGnt (registered one-hot), oAck (= oGnt & iReq),
//                   oRValid (registered), oRData (= mem_rdata), oOwner (3 = idle),
//                   oCpuStall, mem_en/mem_we/mem_addr/mem_wdata
module dbus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dbus_arbiter_if.slave  bus
);

    localparam int             BW         = $clog2(MAX_BEATS + 1);
    // Beat counter value seen while the MAX_BEATS-th beat is being accepted.
    localparam logic [BW-1:0]  FINAL_BEAT = BW'(MAX_BEATS - 1);
    localparam logic [1:0]     NO_OWNER   = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [2:0]      gnt_q,   gnt_d;
    logic [1:0]      last_q,  last_d;
    logic [BW-1:0]   beat_q,  beat_d;
    logic [2:0]      rvalid_q;

    logic [2:0]          ack;
    logic [2:0]          rvalid_d;
    logic [2:0]          pick;
    logic                release_now;
    logic                mem_en_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    // Round-robin pick: search last+1, last+2, last+3 (mod 3).
    // Walking the offsets from lowest to highest priority lets the
    // highest-priority hit overwrite any earlier one.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] win;
        logic [1:0] idx;
        win = '0;
        for (int off = 3; off >= 1; off--) begin
            idx = 2'((int'(last) + off) % 3);
            if (req[idx]) begin
                win = 3'b001 << idx;
            end
        end
        return win;
    endfunction

    function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = NO_OWNER;
        endcase
        return idx;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= NO_OWNER;
            gnt_q    <= '0;
            last_q   <= 2'd2;
            beat_q   <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        beat_d      = beat_q;
        pick        = '0;
        release_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|bus.iReq) begin
                    pick    = rr_pick(bus.iReq, last_q);
                    state_d = S_OWN;
                    gnt_d   = pick;
                    owner_d = oh_to_idx(pick);
                    beat_d  = '0;
                end
            end

            S_OWN: begin
                // Abandon (no request), explicit last beat, or forced release
                // on the MAX_BEATS-th beat. The beat-count term only matters when
                // a beat is accepted because abandon already releases.
                release_now = ~(|ack) | (|(ack & bus.iLast)) | (beat_q == FINAL_BEAT);
                if (release_now) begin
                    last_d = owner_q;
                    // Masking the outgoing owner keeps it from being regranted
                    // back-to-back even if it still holds iReq (forced release).
                    pick   = rr_pick(bus.iReq & ~gnt_q, owner_q);
                    beat_d = '0;
                    if (|pick) begin
                        state_d = S_OWN;
                        gnt_d   = pick;
                        owner_d = oh_to_idx(pick);
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        owner_d = NO_OWNER;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                owner_d = NO_OWNER;
                beat_d  = '0;
            end
        endcase
    end

    // Output logic: memory port is a one-hot mux on the registered grant,
    // so it reads all zero while idle.
    always_comb begin
        ack         = gnt_q & bus.iReq;
        mem_en_c    = |ack;
        mem_we_c    = (|(gnt_q & bus.iWe)) & mem_en_c;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        for (int i = 0; i < 3; i++) begin
            if (gnt_q[i]) begin
                mem_addr_c  = mem_addr_c  | bus.iAddr[i*ADDR_W +: ADDR_W];
                mem_wdata_c = mem_wdata_c | bus.iWData[i*DATA_W +: DATA_W];
            end
        end
        // RAM returns data one cycle after an accepted read beat.
        rvalid_d    = ack & ~bus.iWe;
    end

    assign bus.oGnt      = gnt_q;
    assign bus.oOwner    = owner_q;
    assign bus.oAck      = ack;
    assign bus.oRValid   = rvalid_q;
    assign bus.oRData    = bus.mem_rdata;
    assign bus.oCpuStall = bus.iReq[0] & ~gnt_q[0];
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - scoreboard bench for dbus_arbiter
module tb_dbus_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    dbus_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BEATS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic        req_v  [3];
    logic        we_v   [3];
    logic        last_v [3];
    logic [15:0] addr_v [3];
    logic [15:0] wd_v   [3];

    assign bus.iReq   = {req_v[2],  req_v[1],  req_v[0]};
    assign bus.iWe    = {we_v[2],   we_v[1],   we_v[0]};
    assign bus.iLast  = {last_v[2], last_v[1], last_v[0]};
    assign bus.iAddr  = {addr_v[2], addr_v[1], addr_v[0]};
    assign bus.iWData = {wd_v[2],   wd_v[1],   wd_v[0]};

    // RAM: preloaded with 0xA500 + address.
    logic [15:0] ram [256];
    logic [15:0] rdata_r = '0;
    assign bus.mem_rdata = rdata_r;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            rdata_r <= ram[bus.mem_addr[7:0]];
        end
    end

    typedef struct {
        int          idx;
        logic [15:0] data;
    } rv_t;

    int  ack_q [$];
    rv_t rv_q  [$];
    int  rv_cnt [3];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  abort    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected owners on every accepted beat and expected
    // read data on every read-valid pulse.
    always @(negedge clk) begin
        int  e;
        rv_t r;
        if (rst_n) begin
            if (bus.oAck != 3'b000) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 32'(bus.oAck), 32'd0);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_onehot", 32'(bus.oAck), 32'(1 << e));
                    chk("ack_owner", 32'(bus.oOwner), 32'(e));
                end
            end
            if (bus.oRValid != 3'b000) begin
                if (bus.oRValid[0]) rv_cnt[0]++;
                if (bus.oRValid[1]) rv_cnt[1]++;
                if (bus.oRValid[2]) rv_cnt[2]++;
                if (rv_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(bus.oRValid), 32'd0);
                end else begin
                    r = rv_q.pop_front();
                    chk("rvalid_who", 32'(bus.oRValid), 32'(1 << r.idx));
                    chk("rdata", 32'(bus.oRData), 32'(r.data));
                end
            end
        end
    end

    task automatic drive_beat(input logic [1:0] idx, input logic [15:0] a, input logic w,
                              input logic [15:0] d, input logic l);
        req_v[idx]  = 1'b1;
        we_v[idx]   = w;
        addr_v[idx] = a;
        wd_v[idx]   = d;
        last_v[idx] = l;
    endtask

    task automatic idle_req(input logic [1:0] idx);
        req_v[idx]  = 1'b0;
        we_v[idx]   = 1'b0;
        addr_v[idx] = '0;
        wd_v[idx]   = '0;
        last_v[idx] = 1'b0;
    endtask

    // Requester: presents beat b until accepted, then advances; drops iReq
    // the cycle after its last accepted beat. Read beats queue expected data.
    task automatic requester(input logic [1:0] idx, input logic [15:0] base, input int n,
                             input logic w, input logic [15:0] wbase);
        int   b     = 0;
        int   guard = 0;
        logic hit;
        drive_beat(idx, base, w, wbase, n == 1);
        while (b < n && guard < 200) begin
            @(negedge clk);
            hit = bus.oAck[idx];
            if (hit) begin
                if (!w) rv_q.push_back('{idx: int'(idx), data: 16'hA500 + base + 16'(b)});
                b++;
            end
            @(posedge clk);
            #1;
            guard++;
            if (abort) break;
            if (b < n) drive_beat(idx, base + 16'(b), w, wbase + 16'(b), b == n - 1);
            else       idle_req(idx);
        end
        if (abort) idle_req(idx);
        else       chk("beats_done", 32'(b), 32'(n));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int base2;
        int base1;
        int cnt;
        int guard;

        for (int i = 0; i < 256; i++) ram[i] <= 16'hA500 + 16'(i);
        for (int i = 0; i < 3; i++) idle_req(2'(i));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",    32'(bus.oGnt),      32'd0);
        chk("rst_owner",  32'(bus.oOwner),    32'd3);
        chk("rst_rvalid", 32'(bus.oRValid),   32'd0);
        chk("rst_ack",    32'(bus.oAck),      32'd0);
        chk("rst_mem_en", 32'(bus.mem_en),    32'd0);
        chk("rst_mem_we", 32'(bus.mem_we),    32'd0);
        chk("rst_addr",   32'(bus.mem_addr),  32'd0);
        chk("rst_wdata",  32'(bus.mem_wdata), 32'd0);
        rst_n = 1'b1;
        step();

        // CPU-only 2-beat read at 0x10/0x11
        ack_q.push_back(0);
        ack_q.push_back(0);
        fork
            requester(2'd0, 16'h0010, 2, 1'b0, 16'h0);
            begin
                @(negedge clk);
                chk("t1_c0_stall",  32'(bus.oCpuStall), 32'd1);
                chk("t1_c0_gnt",    32'(bus.oGnt),      32'd0);
                @(negedge clk);
                chk("t1_c1_gnt",    32'(bus.oGnt),      32'b001);
                chk("t1_c1_stall",  32'(bus.oCpuStall), 32'd0);
                @(negedge clk);
                chk("t1_c2_gnt",    32'(bus.oGnt),      32'b001);
                chk("t1_c2_rvalid", 32'(bus.oRValid),   32'b001);
                @(negedge clk);
                chk("t1_c3_owner",  32'(bus.oOwner),    32'd3);
                chk("t1_c3_rvalid", 32'(bus.oRValid),   32'b001);
                chk("t1_c3_stall",  32'(bus.oCpuStall), 32'd0);
            end
        join

        // Reset, then all three issue 1-beat writes together
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ack_q.push_back(0);
        ack_q.push_back(1);
        ack_q.push_back(2);
        fork
            requester(2'd0, 16'h0030, 1, 1'b1, 16'h1111);
            requester(2'd1, 16'h0031, 1, 1'b1, 16'h2222);
            requester(2'd2, 16'h0032, 1, 1'b1, 16'h3333);
            begin
                @(negedge clk);
                chk("t2_c0_gnt", 32'(bus.oGnt), 32'b000);
                @(negedge clk);
                chk("t2_c1_gnt", 32'(bus.oGnt), 32'b001);
                @(negedge clk);
                chk("t2_c2_gnt", 32'(bus.oGnt), 32'b010);
                @(negedge clk);
                chk("t2_c3_gnt", 32'(bus.oGnt), 32'b100);
            end
        join
        repeat (2) step();
        chk("t2_ram30", 32'(ram[8'h30]), 32'h1111);
        chk("t2_ram31", 32'(ram[8'h31]), 32'h2222);
        chk("t2_ram32", 32'(ram[8'h32]), 32'h3333);

        // ACC 12-beat read, CCD joins a cycle later: forced release after 8
        base2 = rv_cnt[2];
        base1 = rv_cnt[1];
        for (int i = 0; i < 8; i++) ack_q.push_back(2);
        ack_q.push_back(1);
        ack_q.push_back(1);
        for (int i = 0; i < 4; i++) ack_q.push_back(2);
        fork
            requester(2'd2, 16'h0020, 12, 1'b0, 16'h0);
            begin
                step();
                requester(2'd1, 16'h0040, 2, 1'b0, 16'h0);
            end
        join
        repeat (3) step();
        chk("t3_acc_rvalids", 32'(rv_cnt[2] - base2), 32'd12);
        chk("t3_ccd_rvalids", 32'(rv_cnt[1] - base1), 32'd2);

        // CCD abandons on its first granted cycle
        drive_beat(2'd1, 16'h0050, 1'b0, 16'h0, 1'b0);
        step();
        idle_req(2'd1);
        @(negedge clk);
        chk("t4_gnt",     32'(bus.oGnt),   32'b010);
        chk("t4_ack",     32'(bus.oAck),   32'd0);
        chk("t4_mem_en",  32'(bus.mem_en), 32'd0);
        step();
        @(negedge clk);
        chk("t4_gnt_next",   32'(bus.oGnt),   32'd0);
        chk("t4_owner_next", 32'(bus.oOwner), 32'd3);
        chk("t4_mem_en_next", 32'(bus.mem_en), 32'd0);
        step();

        // Reset during beat 3 of a CPU read burst
        ack_q.push_back(0);
        ack_q.push_back(0);
        ack_q.push_back(0);
        fork
            requester(2'd0, 16'h0060, 5, 1'b0, 16'h0);
            begin
                cnt   = 0;
                guard = 0;
                while (cnt < 3 && guard < 50) begin
                    @(negedge clk);
                    if (bus.oAck[0]) cnt++;
                    guard++;
                end
                chk("t5_reached_beat3", 32'(cnt), 32'd3);
                #2;
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                chk("t5_gnt",    32'(bus.oGnt),    32'd0);
                chk("t5_rvalid", 32'(bus.oRValid), 32'd0);
                chk("t5_owner",  32'(bus.oOwner),  32'd3);
                chk("t5_mem_en", 32'(bus.mem_en),  32'd0);
                rv_q.delete();
                @(posedge clk);
                step();
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        chk("t5_ackq_empty", 32'(ack_q.size()), 32'd0);

        // All three active after reset: CPU must win first
        ack_q.push_back(0);
        ack_q.push_back(1);
        ack_q.push_back(2);
        fork
            requester(2'd0, 16'h0070, 1, 1'b0, 16'h0);
            requester(2'd1, 16'h0071, 1, 1'b0, 16'h0);
            requester(2'd2, 16'h0072, 1, 1'b0, 16'h0);
        join
        repeat (3) step();
        chk("end_ackq_empty", 32'(ack_q.size()), 32'd0);
        chk("end_rvq_empty",  32'(rv_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
